// File: rtl/ssd_refresh_ctrl_pkg.sv
// Shared encodings, FSM state type and anode decode for the seven-segment refresh controller.
// Digit-select codes follow the scan order: D1 is the leftmost digit and is scanned first.
package ssd_pkg;

    localparam logic [1:0] SEL_D1 = 2'b11;
    localparam logic [1:0] SEL_D2 = 2'b10;
    localparam logic [1:0] SEL_D3 = 2'b01;
    localparam logic [1:0] SEL_D4 = 2'b00;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } state_t;

    // A set mask bit forces its anode high, so a blanked digit stays dark through its slot.
    function automatic logic [3:0] sel_to_anode(input logic [1:0] sel, input logic [3:0] mask);
        logic [3:0] onehot_low;
        onehot_low = ~(4'b0001 << sel);
        return onehot_low | mask;
    endfunction

endpackage

// File: rtl/ssd_refresh_ctrl_if.sv
// Display-side bundle: enable and blank mask in, digit select, anodes and strobe out.
// master is the controlling client; slave is the refresh controller.
interface ssd_refresh_ctrl_if;
    logic       EN;
    logic [3:0] BLANK_MASK;
    logic [1:0] CONTROL;
    logic [3:0] AN;
    logic       DIGIT_STROBE;

    modport master (
        output EN,
        output BLANK_MASK,
        input  CONTROL,
        input  AN,
        input  DIGIT_STROBE
    );

    modport slave (
        input  EN,
        input  BLANK_MASK,
        output CONTROL,
        output AN,
        output DIGIT_STROBE
    );
endinterface

// File: rtl/ssd_refresh_ctrl_slot.sv
// Slot timer: loadable up-counter with clear/enable and terminal flags for the dead and on phases.
// Clear has priority over load, load over enable; the FSM clears on every phase end so it never overflows.
module ssd_slot_counter #(
    parameter int WIDTH    = 4,
    parameter int DEAD_LEN = 2,
    parameter int ON_LEN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             dead_done,
    output logic             on_done
);

    localparam logic [WIDTH-1:0] DEAD_LAST = WIDTH'(DEAD_LEN - 1);
    localparam logic [WIDTH-1:0] ON_LAST   = WIDTH'(ON_LEN - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign dead_done = (count == DEAD_LAST);
    assign on_done   = (count == ON_LAST);

endmodule

// File: rtl/ssd_refresh_ctrl.sv
// Seven-segment refresh controller: scans 4 digits with per-slot dead time and per-digit blanking.
// All outputs registered; EN low parks in IDLE holding CONTROL, and re-enable resumes at that digit.
module ssd_refresh_ctrl
    import ssd_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic               CLK,
    input  logic               RST,
    ssd_refresh_ctrl_if.slave  bus
);

    localparam int DWELL  = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int ON_LEN = DWELL - BLANK_CYCLES;
    localparam int CW     = (DWELL > 1) ? $clog2(DWELL) : 1;

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL) begin : g_bad_params
        $error("ssd_refresh_ctrl: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DWELL");
    end

    state_t     state;
    logic [1:0] control;
    logic [3:0] an;
    logic       digit_strobe;

    logic dead_done;
    logic on_done;
    logic dead_end;
    logic on_end;
    logic cnt_clear;
    logic cnt_enable;

    assign dead_end = (state == DEAD) && dead_done;
    assign on_end   = (state == ON)   && on_done;

    // Counter restarts at every phase boundary and sits at zero whenever the display is parked.
    assign cnt_clear  = !bus.EN || (state == IDLE) || dead_end || on_end;
    assign cnt_enable = bus.EN && (state != IDLE);

    ssd_slot_counter #(
        .WIDTH    (CW),
        .DEAD_LEN (BLANK_CYCLES),
        .ON_LEN   (ON_LEN)
    ) u_slot (
        .clk       (CLK),
        .rst       (RST),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .load      (1'b0),
        .load_val  ({CW{1'b0}}),
        .dead_done (dead_done),
        .on_done   (on_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            control      <= SEL_D1;
            an           <= AN_OFF;
            digit_strobe <= 1'b0;
        end else begin
            digit_strobe <= 1'b0;
            if (!bus.EN) begin
                // Disable beats a coincident slot end: no advance, no strobe.
                state <= IDLE;
                an    <= AN_OFF;
            end else begin
                case (state)
                    IDLE: begin
                        state <= DEAD;
                        an    <= AN_OFF;
                    end
                    DEAD: begin
                        if (dead_done) begin
                            state <= ON;
                            an    <= sel_to_anode(control, bus.BLANK_MASK);
                        end else begin
                            an    <= AN_OFF;
                        end
                    end
                    ON: begin
                        if (on_done) begin
                            state        <= DEAD;
                            control      <= control - 2'd1;
                            an           <= AN_OFF;
                            digit_strobe <= 1'b1;
                        end else begin
                            an <= sel_to_anode(control, bus.BLANK_MASK);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        an    <= AN_OFF;
                    end
                endcase
            end
        end
    end

    assign bus.CONTROL      = control;
    assign bus.AN           = an;
    assign bus.DIGIT_STROBE = digit_strobe;

endmodule

// File: tb/tb_ssd_refresh_ctrl.sv
// Bench for ssd_refresh_ctrl: slot-position reference model compared every cycle, plus directed literal checks.
module tb_ssd_refresh_ctrl;

    localparam int CLK_FREQ_HZ  = 1000;
    localparam int REFRESH_HZ   = 100;
    localparam int BLANK        = 2;
    localparam int DWELL        = CLK_FREQ_HZ / REFRESH_HZ;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   passed = 0;
    logic cmp_on = 1'b0;
    logic [3:0] prev_an = 4'hF;

    always #5 CLK = ~CLK;

    ssd_refresh_ctrl_if bus();

    ssd_refresh_ctrl #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .REFRESH_HZ   (REFRESH_HZ),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Anode pattern for a lit digit: only the selected, unmasked position is low.
    function automatic logic [3:0] anode_of(input int digit, input logic [3:0] mask);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (i == digit && !mask[i]) ? 1'b0 : 1'b1;
        return r;
    endfunction

    // Model tracks position within the slot: 0..BLANK-1 dark, BLANK..DWELL-1 lit.
    logic       m_act;
    int         m_t;
    logic [1:0] m_ctrl;
    logic [3:0] m_an;
    logic       m_stb;

    always @(posedge CLK or posedge RST) begin : model
        int nt;
        logic [1:0] nc;
        if (RST) begin
            m_act <= 1'b0; m_t <= 0; m_ctrl <= 2'd3; m_an <= 4'hF; m_stb <= 1'b0;
        end else if (!bus.EN) begin
            m_act <= 1'b0; m_t <= 0; m_an <= 4'hF; m_stb <= 1'b0;
        end else if (!m_act) begin
            m_act <= 1'b1; m_t <= 0; m_an <= 4'hF; m_stb <= 1'b0;
        end else begin
            nt = m_t + 1;
            nc = m_ctrl;
            if (nt == DWELL) begin
                nt = 0;
                nc = m_ctrl - 2'd1;
            end
            m_t    <= nt;
            m_ctrl <= nc;
            m_stb  <= (nt == 0);
            m_an   <= (nt >= BLANK) ? anode_of(int'(nc), bus.BLANK_MASK) : 4'hF;
        end
    end

    always @(negedge CLK) begin
        if (cmp_on) begin
            chk("model_an", {28'd0, bus.AN}, {28'd0, m_an});
            chk("model_control", {30'd0, bus.CONTROL}, {30'd0, m_ctrl});
            chk("model_strobe", {31'd0, bus.DIGIT_STROBE}, {31'd0, m_stb});
            chk("single_anode", {31'd0, ($countones(~bus.AN) <= 1)}, 32'd1);
            chk("no_direct_switch",
                {31'd0, !(prev_an != 4'hF && bus.AN != 4'hF && bus.AN != prev_an)}, 32'd1);
            prev_an <= bus.AN;
        end
    end

    initial begin
        int n;
        int ok;
        int bad;
        int last_stb;
        int nstb;
        logic [1:0] seen [4];
        logic [1:0] c;

        RST = 1'b1;
        bus.EN = 1'b0;
        bus.BLANK_MASK = 4'b0000;
        repeat (3) @(negedge CLK);
        chk("reset_an", {28'd0, bus.AN}, 32'hF);
        chk("reset_control", {30'd0, bus.CONTROL}, 32'd3);
        chk("reset_strobe", {31'd0, bus.DIGIT_STROBE}, 32'd0);
        RST = 1'b0;
        cmp_on = 1'b1;

        // Startup latency and first slot shape
        @(negedge CLK);
        bus.EN = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.AN == 4'hF && n < 20);
        chk("startup_edges", n, 32'd3);
        chk("first_an", {28'd0, bus.AN}, 32'h7);
        n = 1;
        do begin tick(); n++; end while (bus.AN == 4'h7 && n < 20);
        chk("on_length", n - 1, 32'd8);
        chk("first_strobe", {31'd0, bus.DIGIT_STROBE}, 32'd1);
        chk("first_advance", {30'd0, bus.CONTROL}, 32'd2);
        tick();
        chk("dead_an_1", {28'd0, bus.AN}, 32'hF);
        chk("strobe_one_cycle", {31'd0, bus.DIGIT_STROBE}, 32'd0);
        tick();
        chk("second_an", {28'd0, bus.AN}, 32'hB);

        // Scan order and strobe spacing over 45 cycles
        nstb = 0;
        last_stb = -1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (bus.DIGIT_STROBE) begin
                if (nstb < 4) seen[nstb] = bus.CONTROL;
                if (last_stb >= 0) chk("strobe_spacing", i - last_stb, DWELL);
                last_stb = i;
                nstb++;
            end
        end
        chk("strobe_count", nstb, 32'd4);
        chk("scan_0", {30'd0, seen[0]}, 32'd1);
        chk("scan_1", {30'd0, seen[1]}, 32'd0);
        chk("scan_2", {30'd0, seen[2]}, 32'd3);
        chk("scan_3", {30'd0, seen[3]}, 32'd2);

        // Blank digit 2 for a whole slot
        @(negedge CLK);
        bus.BLANK_MASK = 4'b0100;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (bus.DIGIT_STROBE && bus.CONTROL == 2'd2) ok = 1;
        end
        chk("wait_ctrl2", ok, 32'd1);
        bad = 0;
        for (int i = 1; i <= DWELL; i++) begin
            tick();
            if (i < DWELL && bus.AN != 4'hF) bad++;
            if (i == DWELL) begin
                chk("masked_slot_strobe", {31'd0, bus.DIGIT_STROBE}, 32'd1);
                chk("masked_slot_next", {30'd0, bus.CONTROL}, 32'd1);
            end
        end
        chk("masked_slot_dark", bad, 32'd0);
        @(negedge CLK);
        bus.BLANK_MASK = 4'b0000;

        // Drop EN mid-ON at digit 01, then resume
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (bus.CONTROL == 2'd1 && bus.AN == 4'hD) ok = 1;
        end
        chk("wait_ctrl1_on", ok, 32'd1);
        repeat (3) tick();
        @(negedge CLK);
        bus.EN = 1'b0;
        tick();
        chk("disable_an", {28'd0, bus.AN}, 32'hF);
        chk("disable_hold_ctrl", {30'd0, bus.CONTROL}, 32'd1);
        chk("disable_no_strobe", {31'd0, bus.DIGIT_STROBE}, 32'd0);
        repeat (3) tick();
        chk("idle_hold_ctrl", {30'd0, bus.CONTROL}, 32'd1);
        @(negedge CLK);
        bus.EN = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.AN == 4'hF && n < 20);
        chk("resume_edges", n, 32'd3);
        chk("resume_an", {28'd0, bus.AN}, 32'hD);

        // Asynchronous reset in the middle of an ON phase
        repeat (2) tick();
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_an", {28'd0, bus.AN}, 32'hF);
        chk("async_rst_control", {30'd0, bus.CONTROL}, 32'd3);
        chk("async_rst_strobe", {31'd0, bus.DIGIT_STROBE}, 32'd0);
        @(negedge CLK);
        tick();
        @(negedge CLK);
        RST = 1'b0;

        // EN falls exactly on the terminal ON cycle
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick();
            if (bus.DIGIT_STROBE) ok = 1;
        end
        chk("wait_strobe", ok, 32'd1);
        c = bus.CONTROL;
        chk("post_reset_advance", {30'd0, c}, 32'd2);
        repeat (DWELL - 1) tick();
        chk("terminal_lit", {28'd0, bus.AN}, 32'hB);
        @(negedge CLK);
        bus.EN = 1'b0;
        tick();
        chk("term_no_strobe", {31'd0, bus.DIGIT_STROBE}, 32'd0);
        chk("term_ctrl_held", {30'd0, bus.CONTROL}, 32'd2);
        chk("term_an_off", {28'd0, bus.AN}, 32'hF);

        // Randomized enable and mask traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            bus.EN = ($urandom_range(0, 99) < 96);
            if ($urandom_range(0, 9) == 0) bus.BLANK_MASK = 4'($urandom_range(0, 15));
        end
        @(negedge CLK);
        cmp_on = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ssd_refresh_ctrl.md
# ssd_refresh_ctrl

Time-multiplexing controller for the 4-digit seven-segment display (SSD). It generates the 2-bit digit-select code consumed by the digit multiplexer and the matching active-low anode enables. It inserts a programmable dead time between digits to suppress ghosting and supports per-digit blanking. It sits directly upstream of the digit multiplexer: its `CONTROL` output drives that block's `control` input.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 100_000_000: input clock frequency.
- `REFRESH_HZ`, 1000: digit slot rate. `DWELL = CLK_FREQ_HZ/REFRESH_HZ` cycles per digit slot, including dead time.
- `BLANK_CYCLES`, 1000: dead-time cycles per slot, with anodes off. Legal range is 1 ≤ `BLANK_CYCLES` < `DWELL`; elaboration fails otherwise.

Ports:
- `CLK` in 1: system clock. Single clock domain.
- `RST` in 1: reset, asynchronous and active-high.
- `EN` in 1: display enable.
- `BLANK_MASK` in 4: bit i=1 keeps `AN[i]` off during its slot.
- `CONTROL` out 2: digit-select code sent to the digit multiplexer.
- `AN` out 4: anode enables, active-low, registered.
- `DIGIT_STROBE` out 1: one-cycle pulse when `CONTROL` advances.

## Operation
- Digit mapping: `CONTROL`=11 → `AN[3]`, 10 → `AN[2]`, 01 → `AN[1]`, 00 → `AN[0]`.
- Scan order is 11→10→01→00→11 (decrement, wraps 00→11).
- FSM states:
  - IDLE: anodes off, counter held at 0.
  - DEAD: anodes off, counter runs.
  - ON: the selected anode is driven.
- Reset values: state=IDLE, `CONTROL`=11, `AN`=1111, `DIGIT_STROBE`=0, counter=0.
- IDLE → DEAD on the first edge with `EN`=1. The counter starts at 0.
- DEAD → ON when counter == `BLANK_CYCLES`-1. The counter clears. `AN` drives the one-hot-low bit for `CONTROL`, gated by `BLANK_MASK`.
- ON → DEAD when counter == `DWELL`-`BLANK_CYCLES`-1. On the same edge:
  - `CONTROL` decrements.
  - `AN`=1111.
  - `DIGIT_STROBE`=1 for one cycle.
  - the counter clears.
- In ON, `AN` is re-evaluated every cycle from the current `BLANK_MASK`, so a mask change takes effect on the next edge.
- `EN`=0 in any state → IDLE on the next edge:
  - `AN`=1111.
  - counter=0.
  - `CONTROL` is held, not reset.
  - no strobe.
- Re-enable resumes in DEAD at the held `CONTROL` value.
- Counter width is `$clog2(DWELL)`. The counter never exceeds `DWELL`-1 and never wraps by overflow.
- At most one anode is low in any cycle. `AN` never goes directly from one active digit to another; a full 1111 slot of ≥1 cycle always separates them.

## Timing
- All outputs are registered. There is no combinational path from `EN` or `BLANK_MASK` to outputs.
- Slot length is exactly `DWELL` cycles: `BLANK_CYCLES` with anodes off, then `DWELL`-`BLANK_CYCLES` with the anode on.
- A full frame is 4·`DWELL` cycles. With default parameters: 400_000 cycles, a 250 Hz frame.
- Startup: the first anode goes low `BLANK_CYCLES`+1 edges after the first `EN`=1 sample.
- `DIGIT_STROBE` is asserted in the same cycle the new `CONTROL` first appears. The downstream digit multiplexer and decoder therefore have the full dead time to settle before the anode turns on.
- `RST` asserted mid-slot: outputs take their reset values immediately (asynchronous). Operation restarts from IDLE after deassertion.
- `EN` falling on the same edge as an ON→DEAD transition: the IDLE transition wins. `CONTROL` does not advance and no strobe is issued.

## Structure
- Shared package `ssd_pkg`:
  - `SEL_D1`..`SEL_D4` encodings (11, 10, 01, 00).
  - `AN_OFF` = 4'b1111.
  - the FSM state enum (IDLE, DEAD, ON).
  - the select-to-one-hot-low anode decode function.
- One natural sub-module: `ssd_slot_counter`, a loadable up-counter with clear, enable and terminal-compare outputs for both phase lengths. The FSM, `CONTROL` register and anode register stay in the top level.

## Test plan
Bench parameters: `CLK_FREQ_HZ`=1000, `REFRESH_HZ`=100 (`DWELL`=10), `BLANK_CYCLES`=2.
- Reset, then `EN`=1, `BLANK_MASK`=0000 → `AN`=1111 for 3 edges, then `AN`=0111 for 8 cycles, then 1111 for 2 cycles with `CONTROL`=10 and one strobe, then `AN`=1011.
- Run 45 cycles → `CONTROL` sequence 11,10,01,00,11. Each strobe is exactly 10 cycles apart. `AN` never has two zeros and never changes between two active values directly.
- `BLANK_MASK`=0100 → during the `CONTROL`=10 ON phase `AN`=1111. The slot length and strobe timing are unchanged.
- Drop `EN` mid-ON with `CONTROL`=01 → next edge `AN`=1111 and `CONTROL` stays 01. Re-raise `EN` → 2 dead cycles, then `AN`=1101.
- Assert `RST` asynchronously mid-ON → `AN`=1111, `CONTROL`=11 and `DIGIT_STROBE`=0 without waiting for a clock edge.
- `EN` falls on the terminal ON cycle → no strobe and `CONTROL` unchanged.
